// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO
module uart_rx_fifo #(
    parameter int DIV   = 27,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rxd,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     frame_err,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_nx;
    logic          sync1, sync2;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [3:0]    scnt;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic          sample, push, bad_stop;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          full, pop, do_push;

    assign tick     = (tcnt == TW'(DIV - 1));
    assign full     = (fifo_count == (AW + 1)'(DEPTH));
    assign rx_valid = (fifo_count != '0);
    assign pop      = rx_valid && rx_ready;
    assign do_push  = push && (!full || pop);
    assign rx_data  = rx_valid ? mem[rp] : 8'h00;

    // two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    // oversample tick divider, held at zero in IDLE so each frame starts phase-aligned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tcnt <= '0;
        else
            tcnt <= (state == IDLE || tick) ? '0 : tcnt + 1'b1;
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!sync2) state_nx = START;
            START:     if (tick && scnt == 4'd7) state_nx = sync2 ? IDLE : DATA;
            DATA:      if (sample && bcnt == 3'd7) state_nx = STOP;
            STOP:      if (sample) state_nx = sync2 ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (sync2) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // mid-bit sample strobes and the stop-bit verdict
    always_comb begin
        sample   = tick && scnt == 4'hf && (state == DATA || state == STOP);
        push     = sample && state == STOP && sync2;
        bad_stop = sample && state == STOP && !sync2;
    end

    // sample/bit counters and LSB-first shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            scnt <= (state == IDLE || (state == START && tick && scnt == 4'd7)) ? '0 :
                    tick ? scnt + 1'b1 : scnt;
            bcnt <= (state == IDLE) ? '0 : (state == DATA && sample) ? bcnt + 1'b1 : bcnt;
            if (state == DATA && sample)
                shreg <= {sync2, shreg[7:1]};
        end
    end

    // FIFO storage; contents need no reset because rx_data is masked while empty
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= shreg;
    end

    // FIFO pointers, occupancy and the registered error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wp         <= do_push ? wp + 1'b1 : wp;
            rp         <= pop ? rp + 1'b1 : rp;
            fifo_count <= fifo_count + (AW + 1)'(do_push) - (AW + 1)'(pop);
            frame_err  <= bad_stop;
            overrun    <= push && full && !pop;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed UART frames with a byte scoreboard on the FIFO read side
module tb_uart_rx_fifo;
    localparam int DIV   = 8;
    localparam int DEPTH = 8;
    localparam int BIT   = 16 * DIV;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [$clog2(DEPTH):0] fifo_count;

    int   checks = 0;
    int   errors = 0;
    int   ferr_n = 0;
    int   ovr_n = 0;
    int   val_n = 0;
    time  last_pop_t = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // read-side monitor: counts pulses and compares every popped byte against the scoreboard
    always @(negedge clk) begin
        #1;
        if (frame_err) ferr_n++;
        if (overrun) ovr_n++;
        if (rx_valid) val_n++;
        if (frame_err) check("pulse_overlap", 32'(overrun), 32'd0);
        if (rx_valid && rx_ready) begin
            last_pop_t = $time;
            check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    // drives one frame starting at a falling clock edge; optionally pulses rx_ready on the push cycle
    task automatic send(input logic [7:0] b, input logic stop_v, input int nbits, input bit pop_mark);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        for (int j = 0; j < nbits; j++) begin
            rxd = fr[j];
            for (int i = 0; i < BIT; i++) begin
                if (pop_mark && j == 9 && i == 8 * DIV + 2) rx_ready = 1'b1;
                if (pop_mark && j == 9 && i == 8 * DIV + 3) rx_ready = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_count0"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int f0, o0, v0;
        time t0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (BIT) @(negedge clk);

        rx_ready = 1'b1;
        f0 = ferr_n; o0 = ovr_n; v0 = val_n;
        exp_q.push_back(8'h55);
        t0 = $time;
        send(8'h55, 1'b1, 10, 1'b0);
        repeat (4) @(negedge clk);
        check("b55_valid_cycles", 32'(val_n - v0), 32'd1);
        check("b55_latency", 32'(last_pop_t - t0), 32'((3 + 152 * DIV) * 10 + 1));
        check("b55_ferr", 32'(ferr_n - f0), 32'd0);
        check("b55_ovr", 32'(ovr_n - o0), 32'd0);
        check("b55_received", 32'(exp_q.size()), 32'd0);

        f0 = ferr_n; o0 = ovr_n; v0 = val_n;
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        check("false_start_valid", 32'(val_n - v0), 32'd0);
        check("false_start_ferr", 32'(ferr_n - f0), 32'd0);
        check("false_start_ovr", 32'(ovr_n - o0), 32'd0);
        exp_q.push_back(8'hA3);
        send(8'hA3, 1'b1, 10, 1'b0);
        repeat (4) @(negedge clk);
        check("bA3_received", 32'(exp_q.size()), 32'd0);

        f0 = ferr_n; o0 = ovr_n; v0 = val_n;
        send(8'h3C, 1'b0, 10, 1'b0);
        repeat (2000) @(negedge clk);
        check("brk_ferr_once", 32'(ferr_n - f0), 32'd1);
        check("brk_count", 32'(fifo_count), 32'd0);
        check("brk_ovr", 32'(ovr_n - o0), 32'd0);
        check("brk_valid", 32'(val_n - v0), 32'd0);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1, 10, 1'b0);
        repeat (4) @(negedge clk);
        check("b81_received", 32'(exp_q.size()), 32'd0);
        check("b81_ferr", 32'(ferr_n - f0), 32'd1);

        rx_ready = 1'b0;
        f0 = ferr_n; o0 = ovr_n;
        for (int b = 1; b <= 8; b++) begin
            exp_q.push_back(8'(b));
            send(8'(b), 1'b1, 10, 1'b0);
        end
        repeat (4) @(negedge clk);
        check("fill_count", 32'(fifo_count), 32'd8);
        check("fill_no_ovr", 32'(ovr_n - o0), 32'd0);
        send(8'h09, 1'b1, 10, 1'b0);
        repeat (4) @(negedge clk);
        check("ovr_once", 32'(ovr_n - o0), 32'd1);
        check("ovr_count", 32'(fifo_count), 32'd8);
        check("ovr_ferr", 32'(ferr_n - f0), 32'd0);
        drain("fill");

        for (int b = 8'h10; b <= 8'h17; b++) begin
            exp_q.push_back(8'(b));
            send(8'(b), 1'b1, 10, 1'b0);
        end
        repeat (4) @(negedge clk);
        check("full2_count", 32'(fifo_count), 32'd8);
        o0 = ovr_n;
        exp_q.push_back(8'hEE);
        send(8'hEE, 1'b1, 10, 1'b1);
        repeat (4) @(negedge clk);
        check("simul_no_ovr", 32'(ovr_n - o0), 32'd0);
        check("simul_count", 32'(fifo_count), 32'd8);
        check("simul_sb_left", 32'(exp_q.size()), 32'd8);
        drain("simul");

        rx_ready = 1'b1;
        f0 = ferr_n; o0 = ovr_n; v0 = val_n;
        send(8'h5A, 1'b1, 5, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_pulses", 32'({frame_err, overrun}), 32'd0);
        reset_n = 1'b1;
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("mid_rst_no_valid", 32'(val_n - v0), 32'd0);
        check("mid_rst_no_ferr", 32'(ferr_n - f0), 32'd0);
        check("mid_rst_no_ovr", 32'(ovr_n - o0), 32'd0);
        exp_q.push_back(8'hC7);
        send(8'hC7, 1'b1, 10, 1'b0);
        repeat (4) @(negedge clk);
        check("bC7_received", 32'(exp_q.size()), 32'd0);
        check("bC7_count", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
